// File: rtl/qspi_mem_target_pkg.sv
// Shared constants for the QSPI memory target: FSM encodings, default opcodes
// and counter widths.
package qspi_mem_target_pkg;

   localparam logic [7:0] DEF_CMD_READ  = 8'hEB;
   localparam logic [7:0] DEF_CMD_WRITE = 8'h38;

   localparam int CNT_W        = 4;
   localparam int CMD_BITS     = 8;
   localparam int ADDR_NIBBLES = 6;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE   = 3'd0;
   localparam state_t S_CMD    = 3'd1;
   localparam state_t S_ADDR   = 3'd2;
   localparam state_t S_DUMMY  = 3'd3;
   localparam state_t S_RDATA  = 3'd4;
   localparam state_t S_WDATA  = 3'd5;
   localparam state_t S_IGNORE = 3'd6;

endpackage

// File: rtl/qspi_sync_edge.sv
// Brings CS, SCK and SD into the system clock domain and turns synced SCK
// into single-cycle rise/fall pulses aligned with the synced data.
module qspi_sync_edge (
   input  logic       clk,
   input  logic       rst,
   input  logic       cs_n,
   input  logic       sck,
   input  logic [3:0] sd,
   output logic       cs_n_s,
   output logic [3:0] sd_s,
   output logic       sck_rise,
   output logic       sck_fall
);

   logic [1:0]      cs_ff;
   logic [1:0]      sck_ff;
   logic [1:0][3:0] sd_ff;
   logic            sck_d;

   // CS resets to deselected so the FSM stays idle until a real select.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cs_ff  <= 2'b11;
         sck_ff <= 2'b00;
         sd_ff  <= '0;
         sck_d  <= 1'b0;
      end else begin
         cs_ff  <= {cs_ff[0], cs_n};
         sck_ff <= {sck_ff[0], sck};
         sd_ff  <= {sd_ff[0], sd};
         sck_d  <= sck_ff[1];
      end
   end

   assign cs_n_s   = cs_ff[1];
   assign sd_s     = sd_ff[1];
   assign sck_rise = sck_ff[1] & ~sck_d;
   assign sck_fall = ~sck_ff[1] & sck_d;

endmodule

// File: rtl/qspi_mem_target.sv
// QSPI PSRAM-style target: decodes quad read/write commands and bridges each
// byte onto a req/ack byte memory port, with prefetch on reads.
module qspi_mem_target
   import qspi_mem_target_pkg::*;
#(
   parameter int unsigned ADDR_W    = 24,
   parameter int unsigned DUMMY     = 6,
   parameter logic [7:0]  CMD_READ  = DEF_CMD_READ,
   parameter logic [7:0]  CMD_WRITE = DEF_CMD_WRITE
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              qspi_cs_in,
   input  logic              qspi_sck_i,
   input  logic [3:0]        qspi_sd_i,
   output logic [3:0]        qspi_sd_o,
   output logic [3:0]        qspi_oen_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [7:0]        mem_wdata_o,
   input  logic [7:0]        mem_rdata_i,
   input  logic              mem_ack_i,
   output logic              err_underrun_o,
   output logic              err_overrun_o
);

   logic       cs_n_s, sck_rise, sck_fall;
   logic [3:0] sd_s;

   qspi_sync_edge u_sync (
      .clk      (clk_i),
      .rst      (rst_i),
      .cs_n     (qspi_cs_in),
      .sck      (qspi_sck_i),
      .sd       (qspi_sd_i),
      .cs_n_s   (cs_n_s),
      .sd_s     (sd_s),
      .sck_rise (sck_rise),
      .sck_fall (sck_fall)
   );

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [19:0]       sr;
   logic [ADDR_W-1:0] addr;
   logic              is_rd, wr_lo, rd_lo, dummy_done, rbuf_vld, discard;
   logic [3:0]        wnib, lo_nib;
   logic [7:0]        rbuf;

   logic [7:0]        opcode;
   logic [23:0]       addr_nxt;
   logic [ADDR_W-1:0] addr_in, issue_addr;
   logic              busy, drive_hi, issue_rd, issue_wr;

   assign opcode   = {sr[6:0], sd_s[0]};
   assign addr_nxt = {sr, sd_s};
   assign addr_in  = ADDR_W'(addr_nxt);
   assign busy     = mem_req_o & ~mem_ack_i;
   // Fall that puts out a high nibble: first data byte after the dummies, or any later byte.
   assign drive_hi = ~cs_n_s & sck_fall & ~rd_lo &
                     ((state == S_RDATA) || (state == S_DUMMY && dummy_done));

   always_comb begin
      issue_rd   = 1'b0;
      issue_wr   = 1'b0;
      issue_addr = addr;
      if (drive_hi) begin
         issue_rd   = 1'b1;
         issue_addr = addr + ADDR_W'(1);
      end else if (!cs_n_s && sck_rise && state == S_ADDR && is_rd &&
                   cnt == CNT_W'(ADDR_NIBBLES - 1)) begin
         issue_rd   = 1'b1;
         issue_addr = addr_in;
      end else if (!cs_n_s && sck_rise && state == S_WDATA && wr_lo) begin
         issue_wr   = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state          <= S_IDLE;
         cnt            <= '0;
         sr             <= '0;
         addr           <= '0;
         is_rd          <= 1'b0;
         wr_lo          <= 1'b0;
         rd_lo          <= 1'b0;
         dummy_done     <= 1'b0;
         rbuf_vld       <= 1'b0;
         discard        <= 1'b0;
         wnib           <= '0;
         lo_nib         <= '0;
         rbuf           <= '0;
         qspi_sd_o      <= '0;
         qspi_oen_o     <= '0;
         mem_req_o      <= 1'b0;
         mem_we_o       <= 1'b0;
         mem_addr_o     <= '0;
         mem_wdata_o    <= '0;
         err_underrun_o <= 1'b0;
         err_overrun_o  <= 1'b0;
      end else begin
         // Memory port: a new request may replace one being acked this cycle.
         if ((issue_rd || issue_wr) && !busy) begin
            mem_req_o  <= 1'b1;
            mem_we_o   <= issue_wr;
            mem_addr_o <= issue_addr;
            if (issue_wr) mem_wdata_o <= {wnib, sd_s};
         end else if (mem_ack_i) begin
            mem_req_o <= 1'b0;
         end
         if (mem_ack_i) discard <= 1'b0;
         if (issue_rd && busy) discard <= 1'b1;
         if (issue_wr && busy) err_overrun_o <= 1'b1;
         if (mem_ack_i && mem_req_o && !mem_we_o && !discard && !cs_n_s &&
             (state == S_DUMMY || state == S_RDATA)) begin
            rbuf     <= mem_rdata_i;
            rbuf_vld <= 1'b1;
         end

         if (cs_n_s) begin
            state      <= S_IDLE;
            qspi_oen_o <= '0;
            qspi_sd_o  <= '0;
            rd_lo      <= 1'b0;
            dummy_done <= 1'b0;
            rbuf_vld   <= 1'b0;
            if (busy && !mem_we_o) discard <= 1'b1;
         end else begin
            case (state)
               S_IDLE: begin
                  state <= S_CMD;
                  cnt   <= '0;
               end
               S_CMD: if (sck_rise) begin
                  sr  <= {sr[18:0], sd_s[0]};
                  cnt <= cnt + 1'b1;
                  if (cnt == CNT_W'(CMD_BITS - 1)) begin
                     cnt   <= '0;
                     is_rd <= (opcode == CMD_READ);
                     if (opcode == CMD_READ || opcode == CMD_WRITE) state <= S_ADDR;
                     else                                            state <= S_IGNORE;
                  end
               end
               S_ADDR: if (sck_rise) begin
                  sr  <= addr_nxt[19:0];
                  cnt <= cnt + 1'b1;
                  if (cnt == CNT_W'(ADDR_NIBBLES - 1)) begin
                     cnt      <= '0;
                     addr     <= addr_in;
                     rbuf_vld <= 1'b0;
                     rd_lo    <= 1'b0;
                     wr_lo    <= 1'b0;
                     if (is_rd) begin
                        state      <= S_DUMMY;
                        dummy_done <= (DUMMY == 0);
                     end else begin
                        state <= S_WDATA;
                     end
                  end
               end
               S_DUMMY: if (sck_rise && !dummy_done) begin
                  cnt <= cnt + 1'b1;
                  if (cnt == CNT_W'(DUMMY - 1)) dummy_done <= 1'b1;
               end
               S_RDATA: if (sck_fall && rd_lo) begin
                  qspi_sd_o <= lo_nib;
                  rd_lo     <= 1'b0;
               end
               S_WDATA: if (sck_rise) begin
                  wnib  <= sd_s;
                  wr_lo <= ~wr_lo;
                  if (wr_lo) addr <= addr + ADDR_W'(1);
               end
               default: ;
            endcase
         end

         // High nibble out plus prefetch of the following byte; late data becomes zero.
         if (drive_hi) begin
            state      <= S_RDATA;
            qspi_oen_o <= 4'hF;
            rd_lo      <= 1'b1;
            rbuf_vld   <= 1'b0;
            addr       <= addr + ADDR_W'(1);
            if (rbuf_vld) begin
               qspi_sd_o <= rbuf[7:4];
               lo_nib    <= rbuf[3:0];
            end else begin
               qspi_sd_o      <= 4'h0;
               lo_nib         <= 4'h0;
               err_underrun_o <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_qspi_mem_target.sv
// Directed bench for qspi_mem_target: a QSPI initiator driver plus a simple
// req/ack memory model with per-address slow acks.
module tb_qspi_mem_target;

   logic        clk_i = 1'b0;
   logic        rst_i, qspi_cs_in, qspi_sck_i;
   logic [3:0]  qspi_sd_i, qspi_sd_o, qspi_oen_o;
   logic        mem_req_o, mem_we_o, mem_ack_i;
   logic [23:0] mem_addr_o;
   logic [7:0]  mem_wdata_o, mem_rdata_i;
   logic        err_underrun_o, err_overrun_o;

   int checks = 0, failures = 0;

   qspi_mem_target dut (
      .clk_i(clk_i), .rst_i(rst_i), .qspi_cs_in(qspi_cs_in), .qspi_sck_i(qspi_sck_i),
      .qspi_sd_i(qspi_sd_i), .qspi_sd_o(qspi_sd_o), .qspi_oen_o(qspi_oen_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
      .err_underrun_o(err_underrun_o), .err_overrun_o(err_overrun_o)
   );

   always #5 clk_i = ~clk_i;

   // memory model
   logic [7:0]  mem [logic [23:0]];
   logic [23:0] wlog_a[$];
   logic [7:0]  wlog_d[$];
   int          ack_count = 0;
   logic [23:0] slow_addr = 24'h800000;

   initial begin
      int wcnt;
      wcnt = 0;
      mem_ack_i = 1'b0;
      mem_rdata_i = 8'h00;
      forever begin
         @(negedge clk_i);
         if (mem_ack_i) mem_ack_i = 1'b0;
         else if (!mem_req_o) wcnt = 0;
         else if (mem_addr_o == slow_addr && wcnt < 20) wcnt++;
         else begin
            wcnt = 0;
            mem_ack_i = 1'b1;
            ack_count++;
            if (mem_we_o) begin
               wlog_a.push_back(mem_addr_o);
               wlog_d.push_back(mem_wdata_o);
            end else begin
               mem_rdata_i = mem.exists(mem_addr_o) ? mem[mem_addr_o] : 8'h00;
            end
         end
      end
   end

   initial begin
      #500us;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   // initiator driver
   logic [3:0] last_oe, oen_or, oen_and, pre_oe;
   logic [7:0] rd_data [0:3];

   task automatic sck_cycle(input logic [3:0] d, output logic [3:0] q);
      @(negedge clk_i); qspi_sck_i = 1'b0; qspi_sd_i = d;
      repeat (3) @(negedge clk_i);
      q = qspi_sd_o; last_oe = qspi_oen_o; oen_or = oen_or | qspi_oen_o;
      @(negedge clk_i); qspi_sck_i = 1'b1;
      repeat (3) @(negedge clk_i);
   endtask

   task automatic cs_begin();
      @(negedge clk_i); qspi_cs_in = 1'b0;
      repeat (4) @(negedge clk_i);
   endtask

   task automatic cs_end();
      @(negedge clk_i); qspi_sck_i = 1'b0; qspi_cs_in = 1'b1; qspi_sd_i = 4'h0;
      repeat (6) @(negedge clk_i);
   endtask

   task automatic send_cmd(input logic [7:0] op);
      logic [3:0] q;
      for (int i = 7; i >= 0; i--) sck_cycle({3'b000, op[i]}, q);
   endtask

   task automatic send_addr(input logic [23:0] a, input int n);
      logic [3:0] q;
      for (int i = 0; i < n; i++) sck_cycle(a[23-4*i -: 4], q);
   endtask

   task automatic do_write(input logic [23:0] a, input logic [7:0] b0, b1, b2, input int n);
      logic [3:0]  q;
      logic [23:0] bytes;
      bytes = {b0, b1, b2};
      cs_begin(); oen_or = 4'h0;
      send_cmd(8'h38); send_addr(a, 6);
      for (int i = 0; i < n; i++) begin
         sck_cycle(bytes[23-8*i -: 4], q);
         sck_cycle(bytes[19-8*i -: 4], q);
      end
      cs_end();
      repeat (4) @(negedge clk_i);
   endtask

   // leaves CS asserted so the caller can interpose before ending
   task automatic do_read(input logic [23:0] a, input int nb);
      logic [3:0] q;
      cs_begin(); oen_or = 4'h0;
      send_cmd(8'hEB); send_addr(a, 6);
      for (int i = 0; i < 6; i++) sck_cycle(4'h0, q);
      pre_oe = oen_or; oen_and = 4'hF;
      for (int b = 0; b < nb; b++) begin
         sck_cycle(4'h0, q); rd_data[b][7:4] = q; oen_and = oen_and & last_oe;
         sck_cycle(4'h0, q); rd_data[b][3:0] = q; oen_and = oen_and & last_oe;
      end
   endtask

   // scenarios
   task automatic test_reset();
      rst_i = 1'b1; qspi_cs_in = 1'b1; qspi_sck_i = 1'b0; qspi_sd_i = 4'h0;
      repeat (3) @(negedge clk_i);
      checks++; if (qspi_oen_o !== 4'h0) begin failures++; $display("FAIL reset_oen got=%h exp=0", qspi_oen_o); end
      checks++; if (qspi_sd_o !== 4'h0) begin failures++; $display("FAIL reset_sd got=%h exp=0", qspi_sd_o); end
      checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", mem_req_o); end
      checks++; if (mem_we_o !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", mem_we_o); end
      checks++; if (mem_addr_o !== 24'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", mem_addr_o); end
      checks++; if (mem_wdata_o !== 8'h0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", mem_wdata_o); end
      checks++; if ({err_underrun_o, err_overrun_o} !== 2'b00) begin failures++; $display("FAIL reset_err got=%b exp=00", {err_underrun_o, err_overrun_o}); end
      rst_i = 1'b0;
      repeat (5) @(negedge clk_i);
      checks++; if ({mem_req_o, qspi_oen_o} !== 5'h0) begin failures++; $display("FAIL post_reset_idle got=%h exp=0", {mem_req_o, qspi_oen_o}); end
   endtask

   task automatic test_write();
      int b;
      b = wlog_a.size();
      do_write(24'h000010, 8'hA5, 8'h3C, 8'h00, 2);
      checks++; if (wlog_a.size() !== b + 2) begin failures++; $display("FAIL write_count got=%0d exp=%0d", wlog_a.size(), b + 2); end
      checks++; if ({wlog_a[b], wlog_d[b]} !== {24'h000010, 8'hA5}) begin failures++; $display("FAIL write_b0 got=%h/%h exp=000010/a5", wlog_a[b], wlog_d[b]); end
      checks++; if ({wlog_a[b+1], wlog_d[b+1]} !== {24'h000011, 8'h3C}) begin failures++; $display("FAIL write_b1 got=%h/%h exp=000011/3c", wlog_a[b+1], wlog_d[b+1]); end
      checks++; if (oen_or !== 4'h0) begin failures++; $display("FAIL write_oen got=%h exp=0", oen_or); end
      checks++; if ({err_underrun_o, err_overrun_o} !== 2'b00) begin failures++; $display("FAIL write_err got=%b exp=00", {err_underrun_o, err_overrun_o}); end
   endtask

   task automatic test_read();
      mem[24'h000010] = 8'hA5; mem[24'h000011] = 8'h3C;
      do_read(24'h000010, 2);
      cs_end();
      checks++; if (rd_data[0] !== 8'hA5) begin failures++; $display("FAIL read_b0 got=%h exp=a5", rd_data[0]); end
      checks++; if (rd_data[1] !== 8'h3C) begin failures++; $display("FAIL read_b1 got=%h exp=3c", rd_data[1]); end
      checks++; if (pre_oe !== 4'h0) begin failures++; $display("FAIL read_oen_early got=%h exp=0", pre_oe); end
      checks++; if (oen_and !== 4'hF) begin failures++; $display("FAIL read_oen_data got=%h exp=f", oen_and); end
      checks++; if (qspi_oen_o !== 4'h0) begin failures++; $display("FAIL read_oen_after_cs got=%h exp=0", qspi_oen_o); end
      checks++; if (err_underrun_o !== 1'b0) begin failures++; $display("FAIL read_underrun got=%b exp=0", err_underrun_o); end
   endtask

   task automatic test_ignore();
      int a, b;
      logic [3:0] q;
      a = ack_count; b = wlog_a.size();
      cs_begin(); oen_or = 4'h0;
      send_cmd(8'h9F);
      for (int i = 0; i < 16; i++) sck_cycle(4'(i), q);
      cs_end();
      checks++; if (ack_count !== a) begin failures++; $display("FAIL ignore_no_access got=%0d exp=%0d", ack_count, a); end
      checks++; if (oen_or !== 4'h0) begin failures++; $display("FAIL ignore_oen got=%h exp=0", oen_or); end
      do_write(24'h000030, 8'h5A, 8'hC3, 8'h00, 2);
      checks++; if (wlog_a.size() !== b + 2) begin failures++; $display("FAIL ignore_next_count got=%0d exp=%0d", wlog_a.size(), b + 2); end
      checks++; if ({wlog_a[b], wlog_d[b]} !== {24'h000030, 8'h5A}) begin failures++; $display("FAIL ignore_next_b0 got=%h/%h exp=000030/5a", wlog_a[b], wlog_d[b]); end
      checks++; if ({wlog_a[b+1], wlog_d[b+1]} !== {24'h000031, 8'hC3}) begin failures++; $display("FAIL ignore_next_b1 got=%h/%h exp=000031/c3", wlog_a[b+1], wlog_d[b+1]); end
   endtask

   task automatic test_abort();
      int a;
      a = ack_count;
      cs_begin();
      send_cmd(8'h38); send_addr(24'h123456, 3);
      cs_end();
      repeat (20) @(negedge clk_i);
      checks++; if (ack_count !== a) begin failures++; $display("FAIL abort_no_access got=%0d exp=%0d", ack_count, a); end
      mem[24'h000020] = 8'hC3; mem[24'h000021] = 8'h7E;
      do_read(24'h000020, 2);
      cs_end();
      checks++; if (rd_data[0] !== 8'hC3) begin failures++; $display("FAIL abort_read_b0 got=%h exp=c3", rd_data[0]); end
      checks++; if (rd_data[1] !== 8'h7E) begin failures++; $display("FAIL abort_read_b1 got=%h exp=7e", rd_data[1]); end
   endtask

   task automatic test_wrap();
      int b;
      b = wlog_a.size();
      do_write(24'hFFFFFF, 8'h11, 8'h22, 8'h00, 2);
      checks++; if (wlog_a.size() !== b + 2) begin failures++; $display("FAIL wrap_count got=%0d exp=%0d", wlog_a.size(), b + 2); end
      checks++; if ({wlog_a[b], wlog_d[b]} !== {24'hFFFFFF, 8'h11}) begin failures++; $display("FAIL wrap_b0 got=%h/%h exp=ffffff/11", wlog_a[b], wlog_d[b]); end
      checks++; if ({wlog_a[b+1], wlog_d[b+1]} !== {24'h000000, 8'h22}) begin failures++; $display("FAIL wrap_b1 got=%h/%h exp=000000/22", wlog_a[b+1], wlog_d[b+1]); end
   endtask

   task automatic test_underrun();
      mem[24'h000040] = 8'h96; mem[24'h000041] = 8'hFF;
      slow_addr = 24'h000041;
      do_read(24'h000040, 2);
      cs_end();
      repeat (30) @(negedge clk_i);
      slow_addr = 24'h800000;
      checks++; if (rd_data[0] !== 8'h96) begin failures++; $display("FAIL underrun_b0 got=%h exp=96", rd_data[0]); end
      checks++; if (rd_data[1] !== 8'h00) begin failures++; $display("FAIL underrun_b1 got=%h exp=00", rd_data[1]); end
      checks++; if (err_underrun_o !== 1'b1) begin failures++; $display("FAIL underrun_flag got=%b exp=1", err_underrun_o); end
      checks++; if (err_overrun_o !== 1'b0) begin failures++; $display("FAIL underrun_no_overrun got=%b exp=0", err_overrun_o); end
   endtask

   task automatic test_overrun();
      int b;
      b = wlog_a.size();
      slow_addr = 24'h000050;
      do_write(24'h000050, 8'h11, 8'h22, 8'h33, 3);
      repeat (10) @(negedge clk_i);
      slow_addr = 24'h800000;
      checks++; if (wlog_a.size() !== b + 2) begin failures++; $display("FAIL overrun_count got=%0d exp=%0d", wlog_a.size(), b + 2); end
      checks++; if ({wlog_a[b], wlog_d[b]} !== {24'h000050, 8'h11}) begin failures++; $display("FAIL overrun_b0 got=%h/%h exp=000050/11", wlog_a[b], wlog_d[b]); end
      checks++; if ({wlog_a[b+1], wlog_d[b+1]} !== {24'h000052, 8'h33}) begin failures++; $display("FAIL overrun_b2 got=%h/%h exp=000052/33", wlog_a[b+1], wlog_d[b+1]); end
      checks++; if (err_overrun_o !== 1'b1) begin failures++; $display("FAIL overrun_flag got=%b exp=1", err_overrun_o); end
   endtask

   task automatic test_reset_mid();
      mem[24'h000060] = 8'hD2;
      slow_addr = 24'h000061;
      do_read(24'h000060, 0);
      begin
         logic [3:0] q;
         sck_cycle(4'h0, q);
         checks++; if (q !== 4'hD) begin failures++; $display("FAIL rstmid_nibble got=%h exp=d", q); end
      end
      checks++; if (qspi_oen_o !== 4'hF) begin failures++; $display("FAIL rstmid_oen_before got=%h exp=f", qspi_oen_o); end
      checks++; if (mem_req_o !== 1'b1) begin failures++; $display("FAIL rstmid_req_before got=%b exp=1", mem_req_o); end
      checks++; if ({err_underrun_o, err_overrun_o} !== 2'b11) begin failures++; $display("FAIL rstmid_err_before got=%b exp=11", {err_underrun_o, err_overrun_o}); end
      @(negedge clk_i); #2 rst_i = 1'b1; #1;
      checks++; if (qspi_oen_o !== 4'h0) begin failures++; $display("FAIL rstmid_oen got=%h exp=0", qspi_oen_o); end
      checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL rstmid_req got=%b exp=0", mem_req_o); end
      checks++; if ({err_underrun_o, err_overrun_o} !== 2'b00) begin failures++; $display("FAIL rstmid_err got=%b exp=00", {err_underrun_o, err_overrun_o}); end
      qspi_cs_in = 1'b1; qspi_sck_i = 1'b0;
      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;
      slow_addr = 24'h800000;
      repeat (5) @(negedge clk_i);
      checks++; if ({qspi_oen_o, mem_req_o, err_underrun_o, err_overrun_o} !== 7'h0) begin failures++; $display("FAIL rstmid_after got=%h exp=0", {qspi_oen_o, mem_req_o, err_underrun_o, err_overrun_o}); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_ignore();
      test_abort();
      test_wrap();
      test_underrun();
      test_overrun();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/qspi_mem_target.md
Name: qspi_mem_target

Overview:
- Synthesizable QSPI memory responder, the target end of the SoC's QSPI XIP memory initiator.
- Decodes the PSRAM-style command subset: 0xEB quad read and 0x38 quad write.
- Bridges each decoded byte to a simple req/ack byte-wide memory port.
- Oversamples SCK in the system clock domain. Uses: FPGA emulation of the PSRAM, and on-chip loopback of the secondary XIP port.

Parameters:
- ADDR_W, 24, byte address width; address wraps modulo 2^ADDR_W.
- DUMMY, 6, dummy SCK cycles between address and read data.
- CMD_READ, 8'hEB, quad read opcode.
- CMD_WRITE, 8'h38, quad write opcode.

Ports:
- clk_i  in  1  system clock; must be at least 4x SCK.
- rst_i  in  1  reset, asynchronous, active-high.
- qspi_cs_in  in  1  chip select, active-low.
- qspi_sck_i  in  1  QSPI clock, CPOL=0.
- qspi_sd_i  in  4  data in.
- qspi_sd_o  out  4  data out.
- qspi_oen_o  out  4  output enable per line, 1 = drive.
- mem_req_o  out  1  memory request; held until ack.
- mem_we_o  out  1  1 = write.
- mem_addr_o  out  ADDR_W  byte address.
- mem_wdata_o  out  8  write data.
- mem_rdata_i  in  8  read data, valid with ack.
- mem_ack_i  in  1  one-cycle ack; completes the request.
- err_underrun_o  out  1  sticky: read data not ready in time.
- err_overrun_o  out  1  sticky: write byte dropped.

Behaviour:
- Reset values: all outputs 0; state IDLE; address register 0.
- Synchronizers: qspi_cs_in, qspi_sck_i and qspi_sd_i each pass through a 2-FF synchronizer.
- Edge detect on synced SCK gives rise/fall pulses. Input-to-action latency is 3 clk.
- Rising edge: sample qspi_sd_i. Falling edge: update qspi_sd_o.
- Synced CS high in any state → IDLE within 3 clk. Then oen=0, any pending mem_req_o is held until ack, and the ack data is discarded.
- IDLE: CS falls → CMD, bit counter cleared.
- CMD: 8 rising edges sample io0, MSB first.
  - Opcode = CMD_READ or CMD_WRITE → ADDR.
  - Any other opcode → IGNORE until CS high.
- ADDR: 6 nibbles sampled on 4 lines, MSB nibble first. Bits above ADDR_W are discarded.
  - After the 6th nibble: read → issue mem read of addr, then enter DUMMY; write → WDATA.
- DUMMY: count DUMMY rising edges.
  - On the falling edge after the last dummy rise: set oen=4'hF, drive high nibble of byte 0 → RDATA.
- RDATA: each falling edge drives the next nibble, high nibble then low nibble.
  - Prefetch: when the high nibble of byte N is driven, increment addr and request byte N+1.
  - Underrun: if ack for byte N+1 has not arrived by the falling edge that needs its high nibble, drive 4'h0 for that byte and set err_underrun_o.
  - oen stays 4'hF until CS high.
- WDATA: each rising edge shifts in one nibble. After the 2nd nibble, issue a write of that byte to addr, then increment addr.
  - Overrun: if the previous write is still unacked, drop the byte, set err_overrun_o, and still increment addr.
- Address wrap: 2^ADDR_W−1 + 1 → 0, for both read and write.
- Simultaneous ack and new request in the same cycle: the new request is accepted; mem_req_o stays high with updated fields.
- Error flags clear only on rst_i.
- rst_i asserted mid-transfer: asynchronous. oen=0 and mem_req_o=0 immediately.

Decomposition:
- Package qspi_mem_target_pkg holds:
  - state enum: IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE;
  - default opcode localparams;
  - nibble/bit counter widths.
- One sub-module, qspi_sync_edge: 2-FF synchronizer for CS, SCK and SD, plus SCK rise/fall pulse generation.
- FSM, shift registers and memory port stay in the top module.

Test Plan:
- Write: CS low, 0x38, addr 0x000010, data 0xA5, 0x3C → writes (0x000010, 0xA5) and (0x000011, 0x3C). No errors; oen stays 0 throughout.
- Read: mem model returns 0xA5 at 0x10 and 0x3C at 0x11 with 1-clk ack. Send 0xEB, addr 0x000010, 6 dummy cycles → sampled nibbles A, 5, 3, C; oen=4'hF from the last dummy fall until CS high.
- Unknown opcode 0x9F followed by 16 SCK cycles → no mem_req_o, oen 0. The next valid 0x38 transaction completes correctly.
- CS deasserted after 3 address nibbles → IDLE within 3 clk, no memory access. A following read at 0x000020 returns correct data.
- Address wrap: write at 0xFFFFFF with 2 bytes → writes land at 0xFFFFFF and 0x000000.
- Errors and reset:
  - ack delayed 20 clk during read → 2nd byte reads as 0x00 and err_underrun_o=1;
  - rst_i pulsed mid-read → oen=0 asynchronously and both error flags cleared.
